spi_reg_bridge_burst: RTL
=========================

// Module: spi_reg_bridge_burst
// PURPOSE
//   SPI mode-0 slave that bridges an external host to a TinyQV-style peripheral register port.
//   Next-generation test-harness bridge: parametrised address/data width, auto-increment
//   burst transfers, and a read strobe for clear-on-read registers.
//   Sits between the input synchronizers and the peripheral under test.
//   All SPI inputs arrive already synchronized to clk.
// PARAMETERS
//   ADDR_W   4   register address width, 1..6
//   DATA_W   8   register data width; legal values 8, 16, 32; sent as DATA_W/8 bytes, MSB first
// PORTS
//   clk            in   1        system clock
//   rst_n          in   1        reset, synchronous, active-low
//   spi_cs_n       in   1        chip select, active-low (synchronized)
//   spi_clk        in   1        SPI clock (synchronized); period >= 4 clk
//   spi_mosi       in   1        host data in (synchronized)
//   spi_miso       out  1        slave data out
//   reg_addr       out  ADDR_W   register address to peripheral
//   reg_data_i     in   DATA_W   read data from peripheral (combinational from reg_addr)
//   reg_data_o     out  DATA_W   write data to peripheral
//   reg_data_o_dv  out  1        1-cycle write strobe
//   reg_rd         out  1        1-cycle strobe when reg_data_i is captured for a read
//   busy           out  1        high from cs_n fall until return to IDLE
// BEHAVIOUR
// - Reset (rst_n=0 at a rising clk edge): state IDLE.
//   Reset values: spi_miso=0, reg_addr=0, reg_data_o=0, reg_data_o_dv=0, reg_rd=0, busy=0.
// - Edge detect: spi_clk registered once. rise = ~prev & cur; fall = prev & ~cur.
//   MOSI sampled on rise; MISO changes on fall.
// - Command byte (first 8 bits, MSB first):
//   bit7 = W (1 write / 0 read); bit6 = B (burst auto-increment); bits[ADDR_W-1:0] = address.
//   Other bits ignored.
// - States:
//   IDLE  -(cs_n=0)-> CMD.
//   CMD   -(8th rise)-> WDATA if W, else RLOAD.
//   RLOAD: single cycle. Capture reg_data_i into shift register, pulse reg_rd, drive its MSB on
//          spi_miso, then -> RDATA. MSB must be valid before the host's next rising edge.
//   WDATA: shift in DATA_W bits. On the last rise, the next cycle loads reg_data_o and pulses
//          reg_data_o_dv with reg_addr held stable.
//   RDATA: shift out on each fall. After the last rise of a word -> RLOAD if B, else DONE.
//   WDATA after a completed word: if B, increment reg_addr and stay in WDATA; else -> DONE.
//   DONE: ignore spi_clk, spi_miso=0, until cs_n=1.
// - cs_n=1 in any state -> IDLE next cycle, with precedence over any edge in the same cycle.
//   A partial word is discarded: no strobe and reg_addr unchanged. busy falls and spi_miso=0.
// - Burst increment: reg_addr + 1 modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
//   In a read burst the increment occurs before RLOAD, so each word is captured exactly once.
// - Bit counter: $clog2(DATA_W)+1 bits, cleared at each word/command boundary.
// - reg_data_o holds its last written value until the next write. reg_addr holds after cs_n.
// - At most one of reg_data_o_dv / reg_rd asserts per cycle.
// STRUCTURE
// - Package spi_reg_pkg:
//     state enum {IDLE, CMD, WDATA, RLOAD, RDATA, DONE}
//     localparams CMD_W_BIT=7, CMD_B_BIT=6, CMD_LEN=8
// - Sub-module spi_sclk_edge (registered spi_clk -> rise/fall pulses); reused by other SPI blocks.
// - FSM, bit counter and a single shared DATA_W shift register stay in this module.
// TESTING
// 1. Reset, ADDR_W=4, DATA_W=8: hold rst_n=0 3 cycles -> all outputs 0, busy=0.
// 2. Single write: cmd 0x85, data 0xA5 -> one reg_data_o_dv pulse with reg_addr=5,
//    reg_data_o=0xA5; then DONE, extra clocks ignored.
// 3. Single read: cmd 0x03, peripheral returns 0x3C at addr 3 -> reg_rd pulses once,
//    MISO yields 0x3C MSB first.
// 4. Burst write: cmd 0xCE + 3 bytes 0x11,0x22,0x33 -> strobes at addr 14,15,0 (wrap) in order.
// 5. DATA_W=32 burst read from addr 0x1E (ADDR_W=5): 2 words -> reg_rd at 0x1E, 0x1F,
//    64 bits returned intact.
// 6. Abort: cmd 0x82, 5 data bits, cs_n=1 -> no reg_data_o_dv, busy=0 next cycle.
//    A following transfer works normally.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_pkg : shared state encoding and command-byte layout, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RLOAD = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int CMD_W_BIT = 7;
  localparam int CMD_B_BIT = 6;
  localparam int CMD_LEN   = 8;

endpackage

`default_nettype wire

// File: rtl/spi_sclk_edge.sv
// ---------------------------------------------------------------------------
// spi_sclk_edge : registers a synchronized SPI clock into rise/fall pulses, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sclk_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  output logic rise,
  output logic fall
);

  logic sclk_q;
  logic sclk_d;

  always_comb sclk_d = sclk;

  always_ff @(posedge clk) begin
    if (!rst_n) sclk_q <= 1'b0;
    else        sclk_q <= sclk_d;
  end

  assign rise = sclk & ~sclk_q;
  assign fall = ~sclk & sclk_q;

endmodule

`default_nettype wire

// File: rtl/spi_reg_bridge_burst.sv
// ---------------------------------------------------------------------------
// spi_reg_bridge_burst : SPI mode-0 slave to register-port bridge with bursts, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_reg_bridge_burst
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0] reg_data_o,
  output logic              reg_data_o_dv,
  output logic              reg_rd,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic rise;
  logic fall;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              dv_q, dv_d;
  logic              rd_q, rd_d;
  logic              miso_q, miso_d;
  logic              burst_q, burst_d;
  logic              inc_q, inc_d;

  spi_sclk_edge u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (spi_clk),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dv_d    = 1'b0;
    rd_d    = 1'b0;
    miso_d  = miso_q;
    burst_d = burst_q;
    inc_d   = 1'b0;

    if (spi_cs_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CMD;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end
        CMD: begin
          if (rise) begin
            shreg_d = {shreg_q[DATA_W-2:0], spi_mosi};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CMD_LEN - 1)) begin
              cnt_d   = '0;
              addr_d  = shreg_d[ADDR_W-1:0];
              burst_d = shreg_d[CMD_B_BIT];
              state_d = shreg_d[CMD_W_BIT] ? WDATA : RLOAD;
            end
          end
        end
        WDATA: begin
          // Increment is deferred one cycle so the strobe sees the word's own address.
          if (inc_q) addr_d = addr_q + ADDR_W'(1);
          if (rise) begin
            shreg_d = {shreg_q[DATA_W-2:0], spi_mosi};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d   = '0;
              wdata_d = shreg_d;
              dv_d    = 1'b1;
              if (burst_q) inc_d   = 1'b1;
              else         state_d = DONE;
            end
          end
        end
        RLOAD: begin
          shreg_d = reg_data_i;
          rd_d    = 1'b1;
          miso_d  = reg_data_i[DATA_W-1];
          cnt_d   = '0;
          state_d = RDATA;
        end
        RDATA: begin
          if (rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d = '0;
              if (burst_q) begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = RLOAD;
              end else begin
                miso_d  = 1'b0;
                state_d = DONE;
              end
            end
          end else if (fall && cnt_q != '0) begin
            // The fall preceding a word's first rise must keep the preloaded MSB.
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            miso_d  = shreg_q[DATA_W-2];
          end
        end
        DONE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dv_q    <= 1'b0;
      rd_q    <= 1'b0;
      miso_q  <= 1'b0;
      burst_q <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dv_q    <= dv_d;
      rd_q    <= rd_d;
      miso_q  <= miso_d;
      burst_q <= burst_d;
      inc_q   <= inc_d;
    end
  end

  assign spi_miso      = miso_q;
  assign reg_addr      = addr_q;
  assign reg_data_o    = wdata_q;
  assign reg_data_o_dv = dv_q;
  assign reg_rd        = rd_q;
  assign busy          = (state_q != IDLE);

endmodule

`default_nettype wire
